cmp_search_ctrl: RTL and testbench
==================================

// Module: cmp_search_ctrl
// PURPOSE
//  Successive-approximation search initiator for the cascadable magnitude comparator.
//  - Drives a guess onto the comparator A inputs. An unknown secret sits on the B inputs.
//  - Consumes the comparator's lt/eq/gt answer and binary-searches until eq.
//  - Reports the found value and the number of comparisons used.
//  - Sits between the game/keypad control logic and the comparator.
//  - Comparator cascade inputs are tied off externally: l=0, e=1, g=0.
// PARAMETERS
//  WIDTH   3  operand width; search range is 0 .. 2**WIDTH-1
//  SETTLE  1  cycles guess is held stable before the answer is sampled (>=1)
// PORTS
//  clk      in   1          rising-edge clock
//  rst_n    in   1          asynchronous, active-low reset
//  start    in   1          begin a search; accepted only when not busy
//  guess    out  WIDTH      value driven to comparator A inputs
//  cmp_lt   in   1          comparator: guess < secret
//  cmp_eq   in   1          comparator: guess == secret
//  cmp_gt   in   1          comparator: guess > secret
//  busy     out  1          search in progress
//  done     out  1          level; secret found; held until next accepted start
//  error    out  1          level; inconsistent or illegal answer; held until next start
//  result   out  WIDTH      found value; valid while done=1
//  steps    out  STEP_W     comparisons issued; STEP_W = $clog2(WIDTH+2)
// BEHAVIOUR
//  - Reset is asynchronous; all outputs are 0 and the state is IDLE.
//  - States: IDLE, DRIVE, SAMPLE, DONE, ERR. Registers: lo, hi (WIDTH+1 bits), settle counter, steps.
//  - Start: start=1 in IDLE, DONE or ERR does the following:
//    - lo=0, hi=2**WIDTH-1, steps=0, done=0, error=0.
//    - Move to DRIVE. busy=1 from the next cycle.
//  - start while busy is ignored.
//  - DRIVE:
//    - guess = lo + ((hi-lo)>>1), registered, stable for the whole DRIVE+SAMPLE window.
//    - Stay SETTLE cycles, then go to SAMPLE.
//    - Each comparison costs SETTLE+1 cycles.
//  - SAMPLE: steps increments. The answer must be exactly one-hot over {lt,eq,gt}.
//    - eq: result=guess; go to DONE. done=1, busy=0.
//    - lt: lo=guess+1. gt: hi=guess-1. Both use WIDTH+1-bit arithmetic.
//    - After lt/gt, if lo>hi go to ERR (error=1, busy=0); otherwise go back to DRIVE.
//    - Answer not one-hot (zero or multiple bits set): go to ERR. result is unchanged.
//  - Boundaries:
//    - guess=0 with gt gives hi=-1 in WIDTH+1 bits, so lo>hi and the block goes to ERR.
//    - guess=max with lt gives lo=2**WIDTH, so the block goes to ERR.
//    - Worst case is WIDTH+1 comparisons; steps never wraps.
//  - DONE/ERR hold all outputs; guess keeps its last value.
//  - Reset mid-search: immediate return to IDLE; no partial result is visible.
// STRUCTURE
//  - Package cmp_pkg holds:
//    - the state enum (IDLE, DRIVE, SAMPLE, DONE, ERR);
//    - response codes RESP_LT, RESP_EQ, RESP_GT, RESP_BAD;
//    - function steps_width(WIDTH).
//  - One sub-module, cmp_resp_decode (combinational):
//    - inputs: cmp_lt, cmp_eq, cmp_gt;
//    - output: a response code. Anything not one-hot maps to RESP_BAD.
//  - FSM, lo/hi datapath and settle/step counters stay in this module.
// TESTING
//  - Bench: WIDTH=3, SETTLE=1.
//  - The comparator model answers from a secret unless a scenario overrides it.
//  - Check busy/done/error and cycle counts throughout.
//  - Scenarios:
//    - secret=5 -> guesses 3(lt),5(eq); result=5, steps=2, done after 4 cycles past start.
//    - secret=7 -> guesses 3,5,6,7; result=7, steps=4 (worst case); secret=0 -> guesses 3,1,0; steps=3.
//    - model always answers gt -> guesses 3,1,0, then error=1, done=0, steps=3.
//    - lt and gt both set on the first sample -> error=1 after 1 comparison; next start clears error and searches normally.
//    - start pulsed again mid-search -> ignored, guess sequence unchanged.
//    - rst_n low mid-search -> all outputs 0 immediately; a new start succeeds.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the successive-approximation comparator search controller:
// FSM states, decoded comparator responses and the step-counter width helper.
package cmp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        RESP_LT,
        RESP_EQ,
        RESP_GT,
        RESP_BAD
    } resp_t;

    // Enough bits to count WIDTH+1 comparisons without wrapping.
    function automatic int steps_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/cmp_resp_decode.sv
// Folds the comparator's lt/eq/gt flags into a single response code;
// anything other than exactly one flag set is reported as RESP_BAD.
module cmp_resp_decode
    import cmp_pkg::*;
(
    input  logic  cmp_lt,
    input  logic  cmp_eq,
    input  logic  cmp_gt,
    output resp_t resp
);

    always_comb begin
        resp = RESP_BAD;
        case ({cmp_lt, cmp_eq, cmp_gt})
            3'b100:  resp = RESP_LT;
            3'b010:  resp = RESP_EQ;
            3'b001:  resp = RESP_GT;
            default: resp = RESP_BAD;
        endcase
    end

endmodule

// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator: drives a guess to a magnitude comparator, narrows
// [lo, hi] from its answers and reports the found value and comparisons used.
module cmp_search_ctrl
    import cmp_pkg::*;
#(
    parameter int  WIDTH  = 3,
    parameter int  SETTLE = 1,
    localparam int STEP_W = steps_width(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [WIDTH-1:0]  guess,
    input  logic              cmp_lt,
    input  logic              cmp_eq,
    input  logic              cmp_gt,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [WIDTH-1:0]  result,
    output logic [STEP_W-1:0] steps
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WIDTH:0] ONE     = (WIDTH + 1)'(1);
    localparam logic [WIDTH:0] MAX_EXT = {1'b0, {WIDTH{1'b1}}};

    state_t            state, state_nxt;
    resp_t             resp;
    logic [WIDTH:0]    lo, lo_nxt, hi, hi_nxt;
    logic [WIDTH-1:0]  guess_nxt, result_nxt;
    logic [STEP_W-1:0] steps_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    // hi goes "negative" (MSB set) only after gt on guess 0; lo exceeds hi
    // after lt on the maximum. Either way the range is exhausted.
    function automatic logic range_empty(input logic [WIDTH:0] l, input logic [WIDTH:0] h);
        return h[WIDTH] || (l > h);
    endfunction

    cmp_resp_decode u_decode (
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .cmp_gt (cmp_gt),
        .resp   (resp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            lo     <= '0;
            hi     <= '0;
            guess  <= '0;
            result <= '0;
            steps  <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            lo     <= lo_nxt;
            hi     <= hi_nxt;
            guess  <= guess_nxt;
            result <= result_nxt;
            steps  <= steps_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // start is a single-cycle request sampled on the rising edge; it is
    // accepted only in IDLE/DONE/ERR and silently dropped while busy.
    always_comb begin
        state_nxt  = state;
        lo_nxt     = lo;
        hi_nxt     = hi;
        guess_nxt  = guess;
        result_nxt = result;
        steps_nxt  = steps;
        cnt_nxt    = cnt;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    lo_nxt    = '0;
                    hi_nxt    = MAX_EXT;
                    steps_nxt = '0;
                    cnt_nxt   = '0;
                    guess_nxt = WIDTH'(MAX_EXT >> 1);
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == CNT_W'(SETTLE - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = SAMPLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SAMPLE: begin
                steps_nxt = steps + STEP_W'(1);
                state_nxt = ERR;
                case (resp)
                    RESP_EQ: begin
                        result_nxt = guess;
                        state_nxt  = DONE;
                    end
                    RESP_LT, RESP_GT: begin
                        if (resp == RESP_LT) lo_nxt = {1'b0, guess} + ONE;
                        else                 hi_nxt = {1'b0, guess} - ONE;
                        if (!range_empty(lo_nxt, hi_nxt)) begin
                            guess_nxt = WIDTH'(lo_nxt + ((hi_nxt - lo_nxt) >> 1));
                            state_nxt = DRIVE;
                        end
                    end
                    default: state_nxt = ERR;
                endcase
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state == DRIVE) || (state == SAMPLE);
    assign done  = (state == DONE);
    assign error = (state == ERR);

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Randomized and directed checks of cmp_search_ctrl against a behavioural
// binary-search model driving an answer-mode-selectable comparator.
module tb_cmp_search_ctrl;

    localparam int W      = 3;
    localparam int SETTLE = 1;
    localparam int MAXV   = (1 << W) - 1;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_ALL_GT = 1;
    localparam int MODE_LT_GT  = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] guess;
    logic         cmp_lt, cmp_eq, cmp_gt;
    logic         busy, done, error;
    logic [W-1:0] result;
    logic [2:0]   steps;

    int mode   = MODE_NORMAL;
    int secret = 0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    int exp_steps, exp_err, exp_found, exp_last_guess;
    int last_result = 0;

    cmp_search_ctrl #(.WIDTH(W), .SETTLE(SETTLE)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .guess  (guess),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .cmp_gt (cmp_gt),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .result (result),
        .steps  (steps)
    );

    always #5 clk = ~clk;

    // Comparator stand-in: truthful against secret unless a scenario overrides it.
    always_comb begin
        cmp_lt = 1'b0;
        cmp_eq = 1'b0;
        cmp_gt = 1'b0;
        case (mode)
            MODE_ALL_GT: cmp_gt = 1'b1;
            MODE_LT_GT: begin
                cmp_lt = 1'b1;
                cmp_gt = 1'b1;
            end
            default: begin
                cmp_lt = int'(guess) < secret;
                cmp_eq = int'(guess) == secret;
                cmp_gt = int'(guess) > secret;
            end
        endcase
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference search over plain integers; hi may go negative.
    task automatic model_search();
        int lo, hi, g;
        lo = 0;
        hi = MAXV;
        exp_steps = 0;
        exp_err = 0;
        exp_found = 0;
        exp_q.delete();
        forever begin
            g = lo + (hi - lo) / 2;
            exp_q.push_back(W'(g));
            exp_last_guess = g;
            exp_steps++;
            if (mode == MODE_LT_GT) begin
                exp_err = 1;
                break;
            end
            if (mode == MODE_ALL_GT || g > secret) hi = g - 1;
            else if (g < secret) lo = g + 1;
            else begin
                exp_found = 1;
                break;
            end
            if (lo > hi) begin
                exp_err = 1;
                break;
            end
        end
    endtask

    task automatic run_search(input int m, input int s, input bit pulse_mid);
        int k, busy_cycles;
        bit have_prev;
        logic [W-1:0] prev;
        mode = m;
        secret = s;
        model_search();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        k = 1;
        busy_cycles = 0;
        have_prev = 1'b0;
        prev = '0;
        while (k <= 40) begin
            if (!busy) break;
            busy_cycles++;
            if (!have_prev || guess != prev) begin
                if (exp_q.size() == 0) check("guess_extra", int'(guess), -1);
                else check("guess_seq", int'(guess), int'(exp_q.pop_front()));
            end
            have_prev = 1'b1;
            prev = guess;
            if (pulse_mid) start = (k == 2);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("terminated", busy, 0);
        check("guess_q_empty", exp_q.size(), 0);
        check("cycles_to_end", k - 1, exp_steps * (SETTLE + 1));
        check("busy_cycles", busy_cycles, exp_steps * (SETTLE + 1));
        if (exp_found != 0) last_result = secret;
        repeat (2) begin
            check("done", done, exp_found);
            check("error", error, exp_err);
            check("steps", steps, exp_steps);
            check("result", result, last_result);
            check("guess_hold", guess, exp_last_guess);
            @(negedge clk);
        end
    endtask

    initial begin
        // reset
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_guess", guess, 0);
        check("rst_result", result, 0);
        check("rst_steps", steps, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // directed scenarios
        run_search(MODE_NORMAL, 5, 1'b0);
        run_search(MODE_NORMAL, 7, 1'b0);
        run_search(MODE_NORMAL, 0, 1'b0);
        run_search(MODE_ALL_GT, 0, 1'b0);
        run_search(MODE_LT_GT, 0, 1'b0);
        run_search(MODE_NORMAL, 2, 1'b0);
        run_search(MODE_NORMAL, 6, 1'b1);

        // reset mid-search
        mode = MODE_NORMAL;
        secret = 7;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_error", error, 0);
        check("midrst_guess", guess, 0);
        check("midrst_result", result, 0);
        check("midrst_steps", steps, 0);
        last_result = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_search(MODE_NORMAL, 3, 1'b0);

        // randomized secrets with idle gaps
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_search(MODE_NORMAL, $urandom_range(0, MAXV), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
